muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit. Parametrised successor of the single-cycle ALU for
//  M-extension ops too costly to do combinationally. Sits beside the ALU in EX: the core issues
//  via valid/ready, stalls until out_valid, then writes back result. One op in flight.

---
 rtl/muldiv_unit.sv | 197 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one op in flight.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle multiplier.
module muldiv_unit #(
    parameter  int XLEN = 32,
    localparam int CNTW = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Handshake: a request is taken on a rising edge where in_valid & in_ready are both high;
    // a result is handed off on a rising edge where out_valid & out_ready are both high.

    state_e            state_q;
    logic [2:0]        op_q;
    logic [CNTW-1:0]   cnt_q;
    logic [2*XLEN-1:0] prod_q;
    logic [XLEN:0]     rem_q;
    logic [XLEN-1:0]   quo_q;
    logic [XLEN-1:0]   b_q;
    logic              neg_q;
    logic              rneg_q;
    logic [XLEN-1:0]   result_q;
    logic              out_valid_q;

    logic [2*XLEN-1:0] prod_d;
    logic [XLEN:0]     rem_d;
    logic [XLEN-1:0]   quo_d;

    logic              a_signed;
    logic              b_signed;
    logic              sa;
    logic              sb;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   special_res;

    logic [XLEN:0]     mul_sum;
    logic [XLEN+1:0]   div_shift;
    logic [XLEN+1:0]   div_diff;

    // Operand classification at accept: MULHSU treats only srca as signed.
    assign a_signed = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    assign b_signed = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    assign sa       = a_signed & srca[XLEN-1];
    assign sb       = b_signed & srcb[XLEN-1];
    assign abs_a    = sa ? -srca : srca;
    assign abs_b    = sb ? -srcb : srcb;

    assign div_zero = op[2] && (srcb == '0);
    assign div_ovf  = ((op == 3'd4) || (op == 3'd6)) &&
                      (srca == {1'b1, {(XLEN-1){1'b0}}}) && (srcb == '1);
    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = op[1] ? srca : '1;
        end else if (div_ovf) begin
            special_res = op[1] ? '0 : srca;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
`endif

    // One multiply step: conditionally add the multiplicand to the upper half, shift right.
    assign mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, b_q} : '0);
    assign prod_d  = {mul_sum, prod_q[XLEN-1:1]};

    // One restoring-divide step: shift in the next dividend bit, keep the difference if non-negative.
    assign div_shift = {rem_q, quo_q[XLEN-1]};
    assign div_diff  = div_shift - {2'b00, b_q};
    assign rem_d     = div_diff[XLEN+1] ? div_shift[XLEN:0] : div_diff[XLEN:0];
    assign quo_d     = {quo_q[XLEN-2:0], ~div_diff[XLEN+1]};

    function automatic logic [XLEN-1:0] mul_pick(input logic [2*XLEN-1:0] p,
                                                 input logic neg,
                                                 input logic [2:0] o);
        logic [2*XLEN-1:0] s;
        s = neg ? -p : p;
        return (o == 3'd0) ? s[XLEN-1:0] : s[2*XLEN-1:XLEN];
    endfunction

    function automatic logic [XLEN-1:0] div_pick(input logic [XLEN-1:0] q,
                                                 input logic [XLEN-1:0] r,
                                                 input logic qneg,
                                                 input logic rneg,
                                                 input logic want_rem);
        logic [XLEN-1:0] qf;
        logic [XLEN-1:0] rf;
        qf = qneg ? -q : q;
        rf = rneg ? -r : r;
        return want_rem ? rf : qf;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            cnt_q       <= '0;
            prod_q      <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            b_q         <= '0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q   <= op;
                        neg_q  <= sa ^ sb;
                        rneg_q <= sa;
                        b_q    <= abs_b;
                        prod_q <= {{XLEN{1'b0}}, abs_a};
                        rem_q  <= '0;
                        quo_q  <= abs_a;
                        if (div_zero || div_ovf) begin
                            result_q    <= special_res;
                            cnt_q       <= '0;
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!op[2]) begin
                            result_q    <= mul_pick(fast_prod, sa ^ sb, op);
                            cnt_q       <= '0;
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                        end
`endif
                        else begin
                            cnt_q   <= CNTW'(XLEN);
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    prod_q <= prod_d;
                    rem_q  <= rem_d;
                    quo_q  <= quo_d;
                    cnt_q  <= cnt_q - CNTW'(1);
                    // Last step: fix up signs on the freshly computed values and finish.
                    if (cnt_q == CNTW'(1)) begin
                        result_q    <= op_q[2] ? div_pick(quo_d, rem_d[XLEN-1:0], neg_q, rneg_q, op_q[1])
                                               : mul_pick(prod_d, neg_q, op_q);
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !flush;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized ops
// checked against a plain-arithmetic reference model.
module tb_muldiv_unit;

    localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif
    localparam int DIV_LAT = XLEN + 1;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] srca;
    logic [XLEN-1:0] srcb;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;
    logic [1:0]      dbg_state;

    int n_tests;
    int n_fail;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .srca      (srca),
        .srcb      (srcb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model straight from the M-extension arithmetic rules.
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa64;
        longint sb64;
        longint p;
        logic [63:0] up;
        sa64 = longint'($signed(a));
        sb64 = longint'($signed(b));
        case (o)
            3'd0: begin p = sa64 * sb64; return p[31:0]; end
            3'd1: begin p = sa64 * sb64; return p[63:32]; end
            3'd2: begin p = sa64 * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                p = sa64 / sb64;
                return p[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                p = sa64 % sb64;
                return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (!o[2]) return MUL_LAT;
        if (b == 32'd0) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return DIV_LAT;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            5: return 32'($urandom_range(0, 50));
            default: return $urandom;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Issue one op and wait for out_valid; cyc counts cycles with cycle 1 right after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int cyc);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_before_issue", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        op       = o;
        srca     = a;
        srcb     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = 3'($urandom_range(0, 7));
        srca     = $urandom;
        srcb     = $urandom;
        cyc      = 1;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        res = result;
    endtask

    task automatic handoff(input int hold);
        repeat (hold) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_after_handoff", {31'b0, out_valid}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] res;
        int cyc;
        issue(o, a, b, res, cyc);
        check({tag, "_result"}, res, ref_model(o, a, b));
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat(o, a, b)));
        handoff(0);
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] held;
        int cyc;
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 3'd0;
        srca      = '0;
        srcb      = '0;

        do_reset();
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_state", {30'b0, dbg_state}, 32'd0);

        // Directed arithmetic cases with known answers.
        issue(3'd0, 32'd7, 32'hFFFFFFFD, res, cyc);
        check("mul_7x-3", res, 32'hFFFFFFEB);
        check("mul_7x-3_latency", 32'(cyc), 32'(MUL_LAT));
        handoff(0);
        run_op("mulh_min_min", 3'd1, 32'h80000000, 32'h80000000);
        check("mulh_min_min_const", ref_model(3'd1, 32'h80000000, 32'h80000000), 32'h40000000);
        run_op("mulhsu_ff", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("mulhu_ff", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
        issue(3'd4, 32'hFFFFFFF9, 32'd2, res, cyc);
        check("div_-7_2", res, 32'hFFFFFFFD);
        handoff(0);
        issue(3'd6, 32'hFFFFFFF9, 32'd2, res, cyc);
        check("rem_-7_2", res, 32'hFFFFFFFF);
        handoff(0);
        issue(3'd5, 32'd100, 32'd7, res, cyc);
        check("divu_100_7", res, 32'd14);
        check("divu_latency", 32'(cyc), 32'(DIV_LAT));
        handoff(0);
        issue(3'd7, 32'd100, 32'd7, res, cyc);
        check("remu_100_7", res, 32'd2);
        handoff(0);

        // Bypass cases: result on the first cycle after accept.
        issue(3'd4, 32'd5, 32'd0, res, cyc);
        check("div_by_zero", res, 32'hFFFFFFFF);
        check("div_by_zero_latency", 32'(cyc), 32'd1);
        handoff(0);
        issue(3'd7, 32'd5, 32'd0, res, cyc);
        check("remu_by_zero", res, 32'd5);
        check("remu_by_zero_latency", 32'(cyc), 32'd1);
        handoff(0);
        issue(3'd4, 32'h80000000, 32'hFFFFFFFF, res, cyc);
        check("div_overflow", res, 32'h80000000);
        check("div_overflow_latency", 32'(cyc), 32'd1);
        handoff(0);
        issue(3'd6, 32'h80000000, 32'hFFFFFFFF, res, cyc);
        check("rem_overflow", res, 32'd0);
        check("rem_overflow_latency", 32'(cyc), 32'd1);
        handoff(0);

        // Back-pressure: result held, no new accept while DONE.
        issue(3'd5, 32'd100, 32'd7, res, cyc);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            op       = 3'd0;
            srca     = $urandom;
            srcb     = $urandom;
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
            check("hold_out_valid", {31'b0, out_valid}, 32'd1);
            check("hold_result", result, 32'd14);
        end
        in_valid = 1'b0;
        handoff(0);

        // Flush mid-divide, then a fresh op must take full latency.
        held = result;
        @(negedge clk);
        in_valid = 1'b1;
        op       = 3'd4;
        srca     = $urandom;
        srcb     = 32'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("calc_busy", {31'b0, busy}, 32'd1);
        check("calc_in_ready", {31'b0, in_ready}, 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        op       = 3'd5;
        srca     = 32'd50;
        srcb     = 32'd5;
        check("flush_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        check("flush_state", {30'b0, dbg_state}, 32'd0);
        check("flush_result_kept", result, held);
        @(posedge clk);
        #1;
        check("flush_no_stale_valid", {31'b0, out_valid}, 32'd0);
        issue(3'd5, 32'd9, 32'd3, res, cyc);
        check("post_flush_divu", res, 32'd3);
        check("post_flush_latency", 32'(cyc), 32'(DIV_LAT));
        handoff(0);

        // Flush while DONE drops out_valid but keeps the result.
        issue(3'd5, 32'd77, 32'd0, res, cyc);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("done_flush_out_valid", {31'b0, out_valid}, 32'd0);
        check("done_flush_result", result, 32'hFFFFFFFF);

        // Reset mid-calc.
        @(negedge clk);
        in_valid = 1'b1;
        op       = 3'd3;
        srca     = $urandom;
        srcb     = $urandom;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Randomized ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 3'($urandom_range(0, 7));
            ra = pick_operand();
            rb = pick_operand();
            issue(ro, ra, rb, res, cyc);
            check("rand_result", res, ref_model(ro, ra, rb));
            check("rand_latency", 32'(cyc), 32'(exp_lat(ro, ra, rb)));
            handoff($urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
